tensor_job_sequencer: RTL and testbench

- Host-side front end that sits directly upstream of ast_tensor_system_sv and drives its full load/compute/read protocol from one command.
- Per job it accepts one command plus a streamed operand sequence: A words, then B words.
- It drives wen/set/data_in to load both operands, pulses start, tracks busy, then issues ren reads.
- Results return to the host on a valid/ready stream, so software no longer hand-sequences the tensor system's control pins.

---
 rtl/tensor_job_sequencer_if.sv | 37 +++
 rtl/tensor_job_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_tensor_job_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_job_sequencer_if.sv
// Host-side command, operand and result streams of the tensor job sequencer.
// master = host, slave = sequencer.
interface tensor_job_sequencer_if #(
    parameter int SIZE      = 4,
    parameter int DATAWIDTH = 14
);
    localparam int LW = $clog2(SIZE) + 1;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LW-1:0]        cmd_depth;
    logic [LW-1:0]        cmd_width;
    logic                 cmd_relu;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic                 job_busy;
    logic                 done;
    logic                 err;

    modport master (
        output cmd_valid, cmd_depth, cmd_width, cmd_relu,
        output in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data,
        input  job_busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_depth, cmd_width, cmd_relu,
        input  in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data,
        output job_busy, done, err
    );
endinterface

// File: rtl/tensor_job_sequencer.sv
// Drives the tensor system load/start/read protocol for one host command
// and returns results on a valid/ready stream.
module tensor_job_sequencer #(
    parameter int SIZE         = 4,
    parameter int DATAWIDTH    = 14,
    parameter int GAP_CYCLES   = 5,
    parameter int START_HOLD   = 5,
    parameter int BUSY_TIMEOUT = 64,
    parameter int READ_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    tensor_job_sequencer_if.slave     host,
    output logic [$clog2(SIZE):0]     ts_depth,
    output logic [$clog2(SIZE):0]     ts_width,
    output logic [DATAWIDTH-1:0]      ts_data_in,
    output logic                      ts_wen,
    output logic                      ts_set,
    output logic                      ts_relu,
    output logic                      ts_start,
    output logic                      ts_ren,
    input  logic                      ts_busy,
    input  logic [DATAWIDTH-1:0]      ts_data_out
);
    localparam int LW   = $clog2(SIZE) + 1;
    localparam int CW   = $clog2(SIZE * SIZE + 1);
    localparam int T1   = (GAP_CYCLES > START_HOLD) ? GAP_CYCLES : START_HOLD;
    localparam int T2   = (BUSY_TIMEOUT > READ_LAT) ? BUSY_TIMEOUT : READ_LAT;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_HOLD - 1);
    localparam logic [TW-1:0] BUSY_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] READ_LAST  = TW'(READ_LAT - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_A    = 4'd1;
    localparam logic [3:0] S_GAP_A     = 4'd2;
    localparam logic [3:0] S_LOAD_B    = 4'd3;
    localparam logic [3:0] S_GAP_B     = 4'd4;
    localparam logic [3:0] S_START     = 4'd5;
    localparam logic [3:0] S_WAIT_HI   = 4'd6;
    localparam logic [3:0] S_WAIT_LO   = 4'd7;
    localparam logic [3:0] S_READ_REQ  = 4'd8;
    localparam logic [3:0] S_READ_WAIT = 4'd9;
    localparam logic [3:0] S_READ_OUT  = 4'd10;
    localparam logic [3:0] S_DONE      = 4'd11;

    logic [3:0]           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        total;
    logic [TW-1:0]        tmr;
    logic                 err_q;
    logic [DATAWIDTH-1:0] out_q;

    logic [CW-1:0] cnt_inc;
    logic [TW-1:0] tmr_inc;
    logic          bad_cmd;
    logic          phase_b;

    assign cnt_inc = cnt + CW'(1);
    assign tmr_inc = tmr + TW'(1);

    assign bad_cmd = (host.cmd_depth == '0)
                  || (host.cmd_width == '0)
                  || (host.cmd_depth > LW'(SIZE))
                  || (host.cmd_width > LW'(SIZE));

    // ts_set marks every phase from the B load through the last read.
    assign phase_b = (state == S_LOAD_B)
                  || (state == S_GAP_B)
                  || (state == S_START)
                  || (state == S_WAIT_HI)
                  || (state == S_WAIT_LO)
                  || (state == S_READ_REQ)
                  || (state == S_READ_WAIT)
                  || (state == S_READ_OUT);

    assign ts_set   = phase_b;
    assign ts_start = (state == S_START);
    assign ts_ren   = (state == S_READ_REQ);

    assign host.cmd_ready = (state == S_IDLE) && !reset;
    assign host.in_ready  = (state == S_LOAD_A)
                         || (state == S_LOAD_B);
    assign host.out_valid = (state == S_READ_OUT);
    assign host.out_data  = out_q;
    assign host.job_busy  = (state != S_IDLE)
                         && (state != S_DONE);
    assign host.done      = (state == S_DONE);
    assign host.err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            total      <= '0;
            tmr        <= '0;
            err_q      <= 1'b0;
            out_q      <= '0;
            ts_depth   <= '0;
            ts_width   <= '0;
            ts_relu    <= 1'b0;
            ts_wen     <= 1'b0;
            ts_data_in <= '0;
        end else begin
            ts_wen <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        ts_depth <= host.cmd_depth;
                        ts_width <= host.cmd_width;
                        ts_relu  <= host.cmd_relu;
                        total    <= CW'(host.cmd_depth)
                                  * CW'(host.cmd_width);
                        cnt      <= '0;
                        tmr      <= '0;
                        err_q    <= bad_cmd;
                        state    <= bad_cmd ? S_DONE : S_LOAD_A;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (host.in_valid) begin
                        ts_wen     <= 1'b1;
                        ts_data_in <= host.in_data;
                        cnt        <= cnt_inc;
                        if (cnt_inc == total) begin
                            cnt   <= '0;
                            state <= (state == S_LOAD_A)
                                   ? S_GAP_A : S_GAP_B;
                        end
                    end
                end
                S_GAP_A, S_GAP_B: begin
                    if (tmr == GAP_LAST) begin
                        tmr   <= '0;
                        state <= (state == S_GAP_A)
                               ? S_LOAD_B : S_START;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_START: begin
                    if (tmr == START_LAST) begin
                        tmr   <= '0;
                        state <= S_WAIT_HI;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_WAIT_HI: begin
                    if (ts_busy) begin
                        tmr   <= '0;
                        state <= S_WAIT_LO;
                    end else if (tmr == BUSY_LAST) begin
                        // Busy never rose: flag it but still drain results.
                        err_q <= 1'b1;
                        tmr   <= '0;
                        state <= S_READ_REQ;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_WAIT_LO: begin
                    if (!ts_busy) begin
                        state <= S_READ_REQ;
                    end
                end
                S_READ_REQ: begin
                    tmr   <= '0;
                    state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (tmr == READ_LAST) begin
                        out_q <= ts_data_out;
                        tmr   <= '0;
                        state <= S_READ_OUT;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_READ_OUT: begin
                    if (host.out_ready) begin
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == total)
                               ? S_DONE : S_READ_REQ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_job_sequencer.sv
// Randomised scoreboard bench for tensor_job_sequencer with a behavioural
// tensor-system stub (row-major load, C = A*B, optional ReLU).
`timescale 1ns/1ps
module tb_tensor_job_sequencer;
    localparam int SZ = 4;
    localparam int DW = 14;
    localparam int LW = 3;
    localparam int START_HOLD = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tensor_job_sequencer_if #(.SIZE(SZ), .DATAWIDTH(DW)) host();

    logic [LW-1:0] ts_depth, ts_width;
    logic [DW-1:0] ts_data_in, ts_data_out;
    logic ts_wen, ts_set, ts_relu, ts_start, ts_ren, ts_busy;

    tensor_job_sequencer #(.SIZE(SZ), .DATAWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .host(host),
        .ts_depth(ts_depth), .ts_width(ts_width),
        .ts_data_in(ts_data_in), .ts_wen(ts_wen),
        .ts_set(ts_set), .ts_relu(ts_relu),
        .ts_start(ts_start), .ts_ren(ts_ren),
        .ts_busy(ts_busy), .ts_data_out(ts_data_out)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Tensor-system stub
    int sa[SZ][SZ], sb[SZ][SZ], sc[SZ][SZ];
    int wa = 0, wb = 0, rd_idx = 0, busy_cnt = 0;
    bit busy_en = 1'b1;
    logic start_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wa = 0; wb = 0; rd_idx = 0; busy_cnt = 0;
            for (int i = 0; i < SZ; i++)
                for (int j = 0; j < SZ; j++) begin
                    sa[i][j] = 0; sb[i][j] = 0; sc[i][j] = 0;
                end
            start_d <= 1'b0;
            ts_busy <= 1'b0;
            ts_data_out <= '0;
        end else begin
            start_d <= ts_start;
            if (ts_wen && ts_width != 0) begin
                if (ts_set) begin
                    sb[wb / int'(ts_width)][wb % int'(ts_width)] = int'($signed(ts_data_in));
                    wb++;
                end else begin
                    sa[wa / int'(ts_width)][wa % int'(ts_width)] = int'($signed(ts_data_in));
                    wa++;
                end
            end
            if (ts_start && !start_d) begin
                for (int i = 0; i < SZ; i++)
                    for (int j = 0; j < SZ; j++) begin
                        int s;
                        s = 0;
                        for (int k = 0; k < SZ; k++) s += sa[i][k] * sb[k][j];
                        if (ts_relu && s < 0) s = 0;
                        sc[i][j] = s;
                    end
                if (busy_en) busy_cnt = 12;
            end
            ts_busy <= (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (ts_ren && ts_width != 0) begin
                ts_data_out <= DW'(sc[rd_idx / int'(ts_width)][rd_idx % int'(ts_width)]);
                rd_idx++;
            end
            if (host.done) begin
                wa = 0; wb = 0; rd_idx = 0;
                for (int i = 0; i < SZ; i++)
                    for (int j = 0; j < SZ; j++) begin
                        sa[i][j] = 0; sb[i][j] = 0;
                    end
            end
        end
    end

    // Protocol event counters
    int n_wen0 = 0, n_wen1 = 0, n_start = 0, n_ren = 0, n_done = 0, n_attr = 0;
    logic [LW-1:0] cur_d = '0, cur_w = '0;
    logic cur_r = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ts_wen && !ts_set) n_wen0++;
            if (ts_wen && ts_set) n_wen1++;
            if (ts_start) n_start++;
            if (ts_ren) n_ren++;
            if (host.done) n_done++;
            if (host.job_busy && (ts_depth != cur_d || ts_width != cur_w
                                  || ts_relu != cur_r)) n_attr++;
        end
    end

    // Scoreboard sink
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_log[$];
    int stall_pct = 0;
    int gap_pct = 0;

    initial begin : sink
        bit held;
        logic [DW-1:0] held_data;
        logic [DW-1:0] e;
        held = 1'b0;
        held_data = '0;
        host.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
                host.out_ready = 1'b0;
            end else if (host.out_valid) begin
                if (held) check("out_stable", host.out_data, held_data);
                if (int'($urandom_range(99)) >= stall_pct) begin
                    host.out_ready = 1'b1;
                    held = 1'b0;
                    rx_log.push_back(host.out_data);
                    if (exp_q.size() == 0) begin
                        check("spurious_out", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", host.out_data, e);
                    end
                end else begin
                    host.out_ready = 1'b0;
                    held = 1'b1;
                    held_data = host.out_data;
                end
            end else begin
                if (held) check("out_dropped", host.out_valid, 1);
                held = 1'b0;
                host.out_ready = 1'($urandom_range(1));
            end
        end
    end

    function automatic bit outs_nonzero();
        return |{host.cmd_ready, host.in_ready, host.out_valid,
                 host.out_data, host.job_busy, host.done, host.err,
                 ts_depth, ts_width, ts_data_in, ts_wen, ts_set,
                 ts_relu, ts_start, ts_ren};
    endfunction

    int ma[SZ][SZ], mb[SZ][SZ];

    task automatic fill(input int d, input int w, input int lo, input int hi);
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin
                ma[i][j] = 0; mb[i][j] = 0;
            end
        for (int i = 0; i < d; i++)
            for (int j = 0; j < w; j++) begin
                ma[i][j] = int'($urandom_range(hi - lo)) + lo;
                mb[i][j] = int'($urandom_range(hi - lo)) + lo;
            end
    endtask

    task automatic run_job(input int d, input int w, input bit relu,
                           input bit exp_err, input int abort_at);
        int b_wen0, b_wen1, b_start, b_ren, b_done, b_attr;
        int words[$];
        bit legal;
        int idx, guard, s, nexp;
        legal = (d > 0) && (w > 0) && (d <= SZ) && (w <= SZ);
        b_wen0 = n_wen0; b_wen1 = n_wen1; b_start = n_start;
        b_ren = n_ren; b_done = n_done; b_attr = n_attr;
        cur_d = LW'(d); cur_w = LW'(w); cur_r = relu;
        if (legal) begin
            for (int i = 0; i < d; i++)
                for (int j = 0; j < w; j++) words.push_back(ma[i][j]);
            for (int i = 0; i < d; i++)
                for (int j = 0; j < w; j++) words.push_back(mb[i][j]);
            if (abort_at < 0)
                for (int i = 0; i < d; i++)
                    for (int j = 0; j < w; j++) begin
                        s = 0;
                        for (int k = 0; k < SZ; k++) s += ma[i][k] * mb[k][j];
                        if (relu && s < 0) s = 0;
                        exp_q.push_back(DW'(s));
                    end
        end
        nexp = legal ? d * w : 0;

        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_depth = LW'(d);
        host.cmd_width = LW'(w);
        host.cmd_relu = relu;
        guard = 0;
        while (!host.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept", host.cmd_ready, 1);
        @(negedge clk);
        host.cmd_valid = 1'b0;

        idx = 0;
        guard = 0;
        while (idx < words.size() && guard < 3000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            if (int'($urandom_range(99)) < gap_pct) begin
                host.in_valid = 1'b0;
            end else begin
                host.in_valid = 1'b1;
                host.in_data = DW'(words[idx]);
                if (host.in_ready) idx++;
            end
            @(negedge clk);
            guard++;
        end
        host.in_valid = 1'b0;

        if (abort_at >= 0) begin
            reset = 1'b1;
            #1;
            check("reset_outputs_zero", outs_nonzero(), 0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            check("no_done_on_reset", n_done - b_done, 0);
            return;
        end
        check("operands_fed", idx, words.size());

        guard = 0;
        while (n_done == b_done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", n_done - b_done, 1);
        if (!legal) check("illegal_done_fast", guard <= 2, 1);
        check("err", host.err, exp_err);
        repeat (2) @(negedge clk);
        check("wen_set0", n_wen0 - b_wen0, nexp);
        check("wen_set1", n_wen1 - b_wen1, nexp);
        check("start_cycles", n_start - b_start, legal ? START_HOLD : 0);
        check("ren_pulses", n_ren - b_ren, nexp);
        check("done_once", n_done - b_done, 1);
        check("ts_attr_stable", n_attr - b_attr, 0);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_job", {host.job_busy, ts_set, host.cmd_ready}, 3'b001);
        check("ts_depth_held", ts_depth, d);
        check("ts_relu_held", ts_relu, relu);
    endtask

    logic [DW-1:0] ref_log[$];

    initial begin : stim
        int d, w;
        host.cmd_valid = 1'b0;
        host.cmd_depth = '0;
        host.cmd_width = '0;
        host.cmd_relu = 1'b0;
        host.in_valid = 1'b0;
        host.in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_state_zero", outs_nonzero(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", host.cmd_ready, 1);

        // Reference 4x4 job
        ma = '{'{5,2,6,1}, '{0,6,2,0}, '{3,8,1,4}, '{1,8,5,6}};
        mb = '{'{7,5,8,0}, '{1,8,2,6}, '{9,4,3,8}, '{5,3,7,9}};
        rx_log.delete();
        run_job(4, 4, 1'b0, 1'b0, -1);
        check("row0_c0", rx_log.size() > 0 ? int'(rx_log[0]) : -1, 96);
        check("row0_c1", rx_log.size() > 1 ? int'(rx_log[1]) : -1, 68);
        check("row0_c2", rx_log.size() > 2 ? int'(rx_log[2]) : -1, 69);
        check("row0_c3", rx_log.size() > 3 ? int'(rx_log[3]) : -1, 69);
        ref_log = rx_log;

        // Same job under input gaps and output stalls
        gap_pct = 50;
        stall_pct = 70;
        rx_log.delete();
        run_job(4, 4, 1'b0, 1'b0, -1);
        check("stall_count", rx_log.size(), ref_log.size());
        for (int k = 0; k < 16; k++)
            check("stall_seq", k < rx_log.size() ? int'(rx_log[k]) : -1,
                  k < ref_log.size() ? int'(ref_log[k]) : -2);

        // Illegal commands
        gap_pct = 0;
        stall_pct = 0;
        run_job(0, 4, 1'b0, 1'b1, -1);
        run_job(2, 5, 1'b0, 1'b1, -1);

        // Busy never rises
        busy_en = 1'b0;
        fill(4, 4, 0, 15);
        run_job(4, 4, 1'b0, 1'b1, -1);
        busy_en = 1'b1;

        // Reset during LOAD_B, then a fresh 2x2 job
        fill(4, 4, 0, 15);
        run_job(4, 4, 1'b0, 1'b0, 16 + 7);
        fill(2, 2, 0, 15);
        run_job(2, 2, 1'b0, 1'b0, -1);

        // ReLU with signed operands, non-square region
        fill(3, 2, -20, 20);
        run_job(3, 2, 1'b1, 1'b0, -1);

        // Random legal jobs
        gap_pct = 30;
        stall_pct = 40;
        for (int n = 0; n < 5; n++) begin
            d = int'($urandom_range(1, SZ));
            w = int'($urandom_range(1, SZ));
            fill(d, w, -30, 30);
            run_job(d, w, 1'($urandom_range(1)), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
